sample_iterator: RTL and testbench

- Rasterizer stage directly upstream of the sample test.
- Accepts one triangle plus its sample-aligned bounding box from the bbox stage.
- Walks every sample location inside the box in raster order, emitting one sample per cycle with the triangle and color attached.
- Stalls the bbox stage through a halt signal while a box is still being walked.

---
 rtl/sample_iterator.sv | 143 ++++++++++++++
 tb/tb_sample_iterator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_iterator.sv
`default_nettype none
// ============================================================================
// Module   : sample_iterator
// Purpose  : Walks every step-aligned sample of a triangle's bounding box in
//            raster order, one sample per cycle, stalling upstream via halt.
// Revision : 1.0
// ============================================================================
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic signed [VERTS*AXIS*SIGFIG-1:0]  tri_R13S,
    input  logic        [COLORS*SIGFIG-1:0]      color_R13U,
    input  logic signed [2*2*SIGFIG-1:0]         box_R13S,
    input  logic                                 validTri_R13H,
    input  logic        [3:0]                    subSample_RnnnnU,
    output logic                                 halt_RnnnnH,
    output logic signed [VERTS*AXIS*SIGFIG-1:0]  tri_R14S,
    output logic        [COLORS*SIGFIG-1:0]      color_R14U,
    output logic signed [2*SIGFIG-1:0]           sample_R14S,
    output logic                                 validSamp_R14H
);

    typedef enum logic [0:0] {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    state_t                               state_q;
    logic signed [VERTS*AXIS*SIGFIG-1:0]  tri_q;
    logic        [COLORS*SIGFIG-1:0]      color_q;
    logic signed [SIGFIG-1:0]             llx_q;
    logic signed [SIGFIG-1:0]             urx_q;
    logic signed [SIGFIG-1:0]             ury_q;
    logic signed [SIGFIG-1:0]             x_q;
    logic signed [SIGFIG-1:0]             y_q;
    logic        [SIGFIG-1:0]             step_q;
    logic                                 valid_q;

    logic        [SIGFIG-1:0]             step_d;
    logic signed [SIGFIG-1:0]             x_d;
    logic signed [SIGFIG-1:0]             y_d;

    logic signed [SIGFIG-1:0]             w_in_llx;
    logic signed [SIGFIG-1:0]             w_in_lly;
    logic signed [SIGFIG-1:0]             w_in_urx;
    logic signed [SIGFIG-1:0]             w_in_ury;
    logic signed [SIGFIG:0]               w_next_x;
    logic signed [SIGFIG:0]               w_next_y;
    logic signed [SIGFIG:0]               w_urx_ext;
    logic signed [SIGFIG:0]               w_ury_ext;
    logic                                 w_x_over;
    logic                                 w_y_over;
    logic                                 w_last;
    logic                                 w_box_ok;
    logic                                 w_capture;

    assign w_in_llx = box_R13S[SIGFIG-1:0];
    assign w_in_lly = box_R13S[2*SIGFIG-1:SIGFIG];
    assign w_in_urx = box_R13S[3*SIGFIG-1:2*SIGFIG];
    assign w_in_ury = box_R13S[4*SIGFIG-1:3*SIGFIG];

    // One extra bit keeps x+step from wrapping past the upper-right corner.
    assign w_next_x  = {x_q[SIGFIG-1], x_q} + {1'b0, step_q};
    assign w_next_y  = {y_q[SIGFIG-1], y_q} + {1'b0, step_q};
    assign w_urx_ext = {urx_q[SIGFIG-1], urx_q};
    assign w_ury_ext = {ury_q[SIGFIG-1], ury_q};

    assign w_x_over  = w_next_x > w_urx_ext;
    assign w_y_over  = w_next_y > w_ury_ext;
    assign w_last    = w_x_over && w_y_over;

    assign halt_RnnnnH = (state_q == TEST) && !w_last;

    assign w_box_ok  = (w_in_llx <= w_in_urx) && (w_in_lly <= w_in_ury);
    assign w_capture = validTri_R13H && !halt_RnnnnH && w_box_ok;

    always_comb begin
        step_d = SIGFIG'(1) << RADIX;
        case (subSample_RnnnnU)
            4'b1000: step_d = SIGFIG'(1) << RADIX;
            4'b0100: step_d = SIGFIG'(1) << (RADIX - 1);
            4'b0010: step_d = SIGFIG'(1) << (RADIX - 2);
            4'b0001: step_d = SIGFIG'(1) << (RADIX - 3);
            default: step_d = SIGFIG'(1) << RADIX;
        endcase
    end

    always_comb begin
        x_d = w_next_x[SIGFIG-1:0];
        y_d = y_q;
        if (w_x_over) begin
            x_d = llx_q;
            y_d = w_next_y[SIGFIG-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
            tri_q   <= '0;
            color_q <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
        end else if (w_capture) begin
            state_q <= TEST;
            tri_q   <= tri_R13S;
            color_q <= color_R13U;
            llx_q   <= w_in_llx;
            urx_q   <= w_in_urx;
            ury_q   <= w_in_ury;
            x_q     <= w_in_llx;
            y_q     <= w_in_lly;
            step_q  <= step_d;
            valid_q <= 1'b1;
        end else if (state_q == TEST) begin
            if (w_last) begin
                state_q <= WAIT;
                valid_q <= 1'b0;
            end else begin
                x_q <= x_d;
                y_q <= y_d;
            end
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = {y_q, x_q};
    assign validSamp_R14H = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_iterator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_iterator
// Purpose  : Directed and randomized bench for sample_iterator against a
//            queue-based reference of the expected sample stream.
// Revision : 1.0
// ============================================================================
module tb_sample_iterator;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int TW     = VERTS*AXIS*SIGFIG;
    localparam int CW     = COLORS*SIGFIG;
    localparam int SW     = 2*SIGFIG;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [TW-1:0]   tri_in = '0;
    logic [CW-1:0]   col_in = '0;
    logic            valid_in = 1'b0;
    logic [3:0]      mode_in = 4'b1000;
    int              b_llx = 0, b_lly = 0, b_urx = 0, b_ury = 0;
    logic [4*SIGFIG-1:0] box_in;

    logic            halt_o;
    logic [TW-1:0]   tri_o;
    logic [CW-1:0]   col_o;
    logic [SW-1:0]   samp_o;
    logic            vsamp_o;

    assign box_in = {b_ury[SIGFIG-1:0], b_urx[SIGFIG-1:0], b_lly[SIGFIG-1:0], b_llx[SIGFIG-1:0]};

    sample_iterator #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (col_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_in),
        .subSample_RnnnnU (mode_in),
        .halt_RnnnnH      (halt_o),
        .tri_R14S         (tri_o),
        .color_R14U       (col_o),
        .sample_R14S      (samp_o),
        .validSamp_R14H   (vsamp_o)
    );

    always #5 clk = ~clk;

    // Reference: the queue holds the samples of the current box still to be shown,
    // its head being the sample on the outputs right now.
    logic [SW-1:0] q[$];
    logic [TW-1:0] exp_tri = '0;
    logic [CW-1:0] exp_col = '0;
    logic [SW-1:0] exp_samp = '0;
    int n_assert = 0;
    int n_fail   = 0;

    function automatic int step_of(logic [3:0] m);
        case (m)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, TW'(vsamp_o), TW'(q.size() > 0));
        chk({tag, ".halt"},  TW'(halt_o),  TW'(q.size() > 1));
        chk({tag, ".sample"}, TW'(samp_o), TW'(exp_samp));
        chk({tag, ".tri"},   tri_o,        exp_tri);
        chk({tag, ".color"}, TW'(col_o),   TW'(exp_col));
    endtask

    task automatic load_box();
        int s;
        s = step_of(mode_in);
        q.delete();
        for (int y = b_lly; y <= b_ury; y += s)
            for (int x = b_llx; x <= b_urx; x += s)
                q.push_back({y[SIGFIG-1:0], x[SIGFIG-1:0]});
    endtask

    task automatic tick(input string tag);
        bit acc;
        acc = valid_in && (q.size() <= 1) && (b_llx <= b_urx) && (b_lly <= b_ury);
        @(posedge clk);
        #1;
        if (acc) begin
            load_box();
            exp_tri = tri_in;
            exp_col = col_in;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end
        if (q.size() > 0) exp_samp = q[0];
        check_outputs(tag);
    endtask

    task automatic present(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] m, input logic v);
        logic [255:0] rnd;
        for (int i = 0; i < 8; i++) rnd[i*32 +: 32] = $urandom;
        tri_in = rnd[TW-1:0];
        for (int i = 0; i < 8; i++) rnd[i*32 +: 32] = $urandom;
        col_in = rnd[CW-1:0];
        b_llx = llx; b_lly = lly; b_urx = urx; b_ury = ury;
        mode_in = m;
        valid_in = v;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_outputs("reset");
        #3 rst = 1'b0;

        // 1 spp 2x2 box
        present(0, 0, 1024, 1024, 4'b1000, 1'b1);
        tick("spp1_c0");
        chk("spp1_first", TW'(samp_o), TW'(48'h000000_000000));
        valid_in = 1'b0;
        repeat (3) tick("spp1_walk");
        chk("spp1_lastsamp", TW'(samp_o), TW'({24'd1024, 24'd1024}));
        tick("spp1_done");

        // 4 spp, mode change mid-walk ignored
        present(0, 0, 512, 0, 4'b0100, 1'b1);
        tick("spp4_c0");
        valid_in = 1'b0;
        mode_in  = 4'b0001;
        repeat (2) tick("spp4_walk");

        // back-to-back boxes
        present(0, 0, 1024, 0, 4'b1000, 1'b1);
        tick("b2b_a");
        present(-1024, -1024, 0, -1024, 4'b1000, 1'b1);
        repeat (2) tick("b2b_hold");
        valid_in = 1'b0;
        repeat (2) tick("b2b_tail");

        // degenerate and inverted boxes
        present(-1024, 2048, -1024, 2048, 4'b1000, 1'b1);
        tick("degen");
        valid_in = 1'b0;
        tick("degen_end");
        present(1024, 0, 0, 0, 4'b1000, 1'b1);
        repeat (2) tick("inverted");
        valid_in = 1'b0;

        // signed box at 1 spp
        present(-2048, -1024, -1024, -1024, 4'b1000, 1'b1);
        tick("signed_c0");
        valid_in = 1'b0;
        repeat (2) tick("signed_walk");

        // async reset during the 2nd sample
        present(0, 0, 1024, 1024, 4'b1000, 1'b1);
        tick("rst_c0");
        valid_in = 1'b0;
        tick("rst_s2");
        #2 rst = 1'b1;
        #1;
        q.delete();
        exp_tri = '0; exp_col = '0; exp_samp = '0;
        check_outputs("async_rst");
        #2 rst = 1'b0;
        present(2048, 1024, 3072, 1024, 4'b1000, 1'b1);
        tick("post_rst_c0");
        valid_in = 1'b0;
        repeat (2) tick("post_rst_walk");

        // randomized traffic
        repeat (400) begin
            int r, s, k;
            logic [3:0] m;
            r = int'($urandom_range(0, 4));
            m = (r < 4) ? (4'b1000 >> r) : 4'($urandom);
            s = step_of(m);
            k = int'($urandom_range(0, 16)) - 8;
            present(k * s, 0, 0, 0, m, $urandom_range(0, 2) != 0);
            k = int'($urandom_range(0, 16)) - 8;
            b_lly = k * s;
            b_urx = b_llx + (int'($urandom_range(0, 4)) - 1) * s;
            b_ury = b_lly + (int'($urandom_range(0, 4)) - 1) * s;
            tick("rand");
        end
        valid_in = 1'b0;
        repeat (20) tick("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
